plusarg_timeout_watchdog: RTL and testbench

Cycle-budget watchdog that consumes a runtime-configured limit (driven by the harness plusarg reader, e.g. `+max_core_cycles=N`) and flags when a design has run too long without forward progress. It sits directly downstream of the plusarg reader in the test harness. It counts enabled cycles since the last progress `kick`, raises a `warn` near the budget, and latches `expired` when the budget is exhausted. A limit of 0 disables it.

---
 rtl/plusarg_timeout_pkg.sv | 16 +
 rtl/plusarg_timeout_watchdog.sv | 101 ++++++++++
 tb/tb_plusarg_timeout_watchdog.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/plusarg_timeout_pkg.sv
// Shared types and defaults for the plusarg-driven cycle-budget watchdog.
// Holds the watchdog state encoding and the default parameter values.
package plusarg_timeout_pkg;

    localparam int unsigned DEFAULT_WIDTH       = 32;
    localparam int unsigned DEFAULT_WARN_MARGIN = 1024;

    // Encodings are visible on the state port, so they are fixed here.
    typedef enum logic [1:0] {
        ST_DISABLED = 2'b00,
        ST_RUN      = 2'b01,
        ST_WARN     = 2'b10,
        ST_EXPIRED  = 2'b11
    } timeout_state_e;

endpackage

// File: rtl/plusarg_timeout_watchdog.sv
// Cycle-budget watchdog: counts enabled cycles since the last kick/clear
// and flags warn near the budget and a sticky expiry when it runs out.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   limit        cycle budget (0 disables the watchdog)
//   enable       count this cycle
//   kick         progress seen, restart the budget
//   clear        leave EXPIRED and zero the counter
//   count        cycles since last kick/clear/reset
//   state        00 DISABLED, 01 RUN, 10 WARN, 11 EXPIRED
//   warn         state == WARN
//   expired      state == EXPIRED (sticky)
//   expire_pulse one-cycle pulse on entry to EXPIRED
module plusarg_timeout_watchdog
    import plusarg_timeout_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned WARN_MARGIN = DEFAULT_WARN_MARGIN
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] limit,
    input  logic             enable,
    input  logic             kick,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic             warn,
    output logic             expired,
    output logic             expire_pulse
);

    localparam logic [WIDTH:0]   MARGIN = (WIDTH + 1)'(WARN_MARGIN);
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH - 1){1'b0}}, 1'b1};

    timeout_state_e   cur_state;
    timeout_state_e   nxt_state;
    logic [WIDTH-1:0] cnt_n;
    logic [WIDTH:0]   gap;
    logic             limit_on;
    logic             pulse_n;

    assign limit_on = |limit;

    // Next count, highest priority first.
    always_comb begin
        cnt_n = count;
        if (clear) begin
            cnt_n = '0;
        end else if (cur_state == ST_EXPIRED) begin
            cnt_n = count;
        end else if (kick) begin
            cnt_n = '0;
        end else if (enable && limit_on) begin
            // Also clamps a count left above a freshly lowered limit.
            cnt_n = (count < limit) ? count + ONE : limit;
        end
        if (!limit_on) begin
            cnt_n = '0;
        end
    end

    // Remaining budget at one extra bit so it never wraps.
    assign gap = {1'b0, limit} - {1'b0, cnt_n};

    always_comb begin
        nxt_state = cur_state;
        if (!limit_on) begin
            nxt_state = ST_DISABLED;
        end else if (cur_state == ST_EXPIRED && !clear) begin
            nxt_state = ST_EXPIRED;
        end else if (cnt_n >= limit) begin
            nxt_state = ST_EXPIRED;
        end else if (gap <= MARGIN) begin
            nxt_state = ST_WARN;
        end else begin
            nxt_state = ST_RUN;
        end
    end

    assign pulse_n = (nxt_state == ST_EXPIRED) && (cur_state != ST_EXPIRED);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count        <= '0;
            cur_state    <= ST_DISABLED;
            expire_pulse <= 1'b0;
        end else begin
            count        <= cnt_n;
            cur_state    <= nxt_state;
            expire_pulse <= pulse_n;
        end
    end

    assign state   = cur_state;
    assign warn    = (cur_state == ST_WARN);
    assign expired = (cur_state == ST_EXPIRED);

endmodule

// File: tb/tb_plusarg_timeout_watchdog.sv
// Self-checking bench for plusarg_timeout_watchdog: directed budget,
// kick, sticky/clear, disable, limit-change and reset steps, then random.
module tb_plusarg_timeout_watchdog;

    localparam int unsigned W  = 32;
    localparam int unsigned WM = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] limit = '0;
    logic         enable = 1'b0;
    logic         kick = 1'b0;
    logic         clear = 1'b0;
    logic [W-1:0] count;
    logic [1:0]   state;
    logic         warn;
    logic         expired;
    logic         expire_pulse;

    int checks = 0;
    int errors = 0;

    // Reference model: count, sticky expiry flag, derived state and pulse.
    logic [W-1:0] m_count = '0;
    bit           m_exp   = 1'b0;
    bit           m_pulse = 1'b0;
    logic [1:0]   m_state = 2'b00;

    plusarg_timeout_watchdog #(
        .WIDTH       (W),
        .WARN_MARGIN (WM)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .limit        (limit),
        .enable       (enable),
        .kick         (kick),
        .clear        (clear),
        .count        (count),
        .state        (state),
        .warn         (warn),
        .expired      (expired),
        .expire_pulse (expire_pulse)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_count = '0;
        m_exp   = 1'b0;
        m_pulse = 1'b0;
        m_state = 2'b00;
    endtask

    // One clock edge of the watchdog's rules, using the inputs at the edge.
    task automatic model_step();
        bit     was;
        longint rem;
        was = m_exp;
        if (limit == 0) begin
            m_count = '0;
            m_exp   = 1'b0;
        end else begin
            if (clear) begin
                m_count = '0;
                m_exp   = 1'b0;
            end else if (!m_exp) begin
                if (kick)
                    m_count = '0;
                else if (enable)
                    m_count = (m_count < limit) ? m_count + 1 : limit;
            end
            if (!m_exp)
                m_exp = (m_count >= limit);
        end
        m_pulse = m_exp && !was;
        rem = longint'(limit) - longint'(m_count);
        if (limit == 0)
            m_state = 2'b00;
        else if (m_exp)
            m_state = 2'b11;
        else if (rem <= longint'(WM))
            m_state = 2'b10;
        else
            m_state = 2'b01;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"}, 64'(count), 64'(m_count));
        chk({tag, ".state"}, 64'(state), 64'(m_state));
        chk({tag, ".warn"}, 64'(warn), 64'(m_state == 2'b10));
        chk({tag, ".expired"}, 64'(expired), 64'(m_exp));
        chk({tag, ".pulse"}, 64'(expire_pulse), 64'(m_pulse));
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        model_step();
        #1;
        check_model(tag);
    endtask

    initial begin
        // Reset state.
        #2;
        chk("rst.count", 64'(count), 64'd0);
        chk("rst.state", 64'(state), 64'd0);
        chk("rst.warn", 64'(warn), 64'd0);
        chk("rst.expired", 64'(expired), 64'd0);
        chk("rst.pulse", 64'(expire_pulse), 64'd0);
        @(negedge clock);
        reset  = 1'b1;
        limit  = 10;
        enable = 1'b1;

        // Budget and pulse.
        for (int e = 1; e <= 12; e++) begin
            tick("budget");
            if (e == 6) chk("budget.nowarn6", 64'(warn), 64'd0);
            if (e == 7) chk("budget.warn7", 64'(warn), 64'd1);
            if (e == 9) chk("budget.noexp9", 64'(expired), 64'd0);
            if (e == 10) begin
                chk("budget.exp10", 64'(expired), 64'd1);
                chk("budget.pulse10", 64'(expire_pulse), 64'd1);
                chk("budget.count10", 64'(count), 64'd10);
            end
            if (e == 11) begin
                chk("budget.pulse11", 64'(expire_pulse), 64'd0);
                chk("budget.count11", 64'(count), 64'd10);
            end
        end

        // Sticky: kicks are ignored while expired.
        kick = 1'b1;
        for (int i = 0; i < 5; i++) tick("sticky.kick");
        chk("sticky.exp", 64'(expired), 64'd1);
        kick  = 1'b0;
        clear = 1'b1;
        tick("clear");
        clear = 1'b0;
        chk("clear.state", 64'(state), 64'd1);
        chk("clear.count", 64'(count), 64'd0);
        chk("clear.exp", 64'(expired), 64'd0);
        for (int e = 1; e <= 10; e++) begin
            tick("reexp");
            if (e == 9) chk("reexp.noexp9", 64'(expired), 64'd0);
            if (e == 10) chk("reexp.exp10", 64'(expired), 64'd1);
        end

        // Kick restart, including kick with the final increment.
        clear = 1'b1;
        tick("kick.clear");
        clear = 1'b0;
        for (int e = 1; e <= 8; e++) tick("kick.pre");
        kick = 1'b1;
        tick("kick.9");
        kick = 1'b0;
        chk("kick9.count", 64'(count), 64'd0);
        chk("kick9.exp", 64'(expired), 64'd0);
        for (int e = 1; e <= 9; e++) tick("kick.run");
        kick = 1'b1;
        tick("kick.10");
        kick = 1'b0;
        chk("kick10.count", 64'(count), 64'd0);
        chk("kick10.exp", 64'(expired), 64'd0);

        // Disable, then re-enable with a short budget.
        limit = 0;
        for (int i = 0; i < 1000; i++) tick("disable");
        chk("disable.state", 64'(state), 64'd0);
        chk("disable.count", 64'(count), 64'd0);
        limit = 5;
        for (int e = 1; e <= 5; e++) begin
            tick("limit5");
            if (e == 4) chk("limit5.noexp4", 64'(expired), 64'd0);
            if (e == 5) chk("limit5.exp5", 64'(expired), 64'd1);
        end

        // Limit lowered below the current count.
        limit = 20;
        clear = 1'b1;
        tick("lower.clear");
        clear = 1'b0;
        for (int e = 1; e <= 8; e++) tick("lower.run");
        chk("lower.count8", 64'(count), 64'd8);
        enable = 1'b0;
        limit  = 4;
        tick("lower.edge");
        chk("lower.exp", 64'(expired), 64'd1);
        chk("lower.pulse", 64'(expire_pulse), 64'd1);
        tick("lower.after");
        chk("lower.pulse2", 64'(expire_pulse), 64'd0);

        // Asynchronous reset mid-count.
        limit  = 10;
        enable = 1'b1;
        clear  = 1'b1;
        tick("arst.clear");
        clear = 1'b0;
        for (int e = 1; e <= 6; e++) tick("arst.run");
        chk("arst.count6", 64'(count), 64'd6);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("arst.count", 64'(count), 64'd0);
        chk("arst.state", 64'(state), 64'd0);
        chk("arst.warn", 64'(warn), 64'd0);
        chk("arst.exp", 64'(expired), 64'd0);
        chk("arst.pulse", 64'(expire_pulse), 64'd0);
        #1;
        reset = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            kick   = ($urandom_range(0, 15) == 0);
            clear  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 39) == 0)
                limit = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 25);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
